// File: rtl/vga_timing_gen_if.sv
// Signal bundle between the raster timing generator, the renderer and the VGA DAC pins.
// The master (the generator) drives the coordinates, strobes and DAC pins; the slave drives en and RGB.
interface vga_timing_gen_if #(
  parameter int HW = 10,
  parameter int VW = 10
);
  logic          en;
  logic [7:0]    rgb_r, rgb_g, rgb_b;
  logic [HW-1:0] pix_hcount;
  logic [VW-1:0] pix_vcount;
  logic          pix_tick, line_start, frame_start, vblank;
  logic [7:0]    vga_r, vga_g, vga_b;
  logic          vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n;

  modport master (
    input  en, rgb_r, rgb_g, rgb_b,
    output pix_hcount, pix_vcount, pix_tick, line_start, frame_start, vblank,
           vga_r, vga_g, vga_b, vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n
  );

  modport slave (
    output en, rgb_r, rgb_g, rgb_b,
    input  pix_hcount, pix_vcount, pix_tick, line_start, frame_start, vblank,
           vga_r, vga_g, vga_b, vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel divider, H/V counters, sync/blank decode,
// a PIPE-tick flag delay matching the renderer latency, and a registered DAC output stage.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE     = 2
) (
  input  logic             clk50,
  input  logic             reset,
  vga_timing_gen_if.master bus
);
  localparam int HTOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VTOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);
  localparam int DW     = 2;

  localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [HW-1:0] H_MAX    = HW'(HTOTAL - 1);
  localparam logic [VW-1:0] V_MAX    = VW'(VTOTAL - 1);
  // One extra bit so a sync window ending exactly at the total still compares correctly.
  localparam logic [HW:0]   H_ACT_E  = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0]   H_SYN_S  = (HW+1)'(H_ACTIVE + H_FP);
  localparam logic [HW:0]   H_SYN_E  = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW:0]   V_ACT_E  = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0]   V_SYN_S  = (VW+1)'(V_ACTIVE + V_FP);
  localparam logic [VW:0]   V_SYN_E  = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          ls_q, ls_d, fs_q, fs_d;
  logic          tick, h_wrap, v_wrap;

  assign tick   = bus.en & (div_q == DIV_MAX);
  assign h_wrap = (h_q == H_MAX);
  assign v_wrap = (v_q == V_MAX);

  always_comb begin
    div_d = div_q;
    h_d   = h_q;
    v_d   = v_q;
    ls_d  = 1'b0;
    fs_d  = 1'b0;
    if (!bus.en) begin
      div_d = '0;
      h_d   = '0;
      v_d   = '0;
    end else begin
      div_d = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
      if (tick) begin
        h_d  = h_wrap ? '0 : h_q + 1'b1;
        if (h_wrap) v_d = v_wrap ? '0 : v_q + 1'b1;
        ls_d = h_wrap;
        fs_d = h_wrap & v_wrap;
      end
    end
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
    end
  end

  // Stage-0 flags {act, hs, vs}, all active-high internally.
  logic [2:0] flg0, flg_dly;
  assign flg0[2] = ({1'b0, h_q} < H_ACT_E) & ({1'b0, v_q} < V_ACT_E);
  assign flg0[1] = ({1'b0, h_q} >= H_SYN_S) & ({1'b0, h_q} < H_SYN_E);
  assign flg0[0] = ({1'b0, v_q} >= V_SYN_S) & ({1'b0, v_q} < V_SYN_E);

  generate
    if (PIPE == 0) begin : g_nodly
      assign flg_dly = flg0;
    end else begin : g_dly
      logic [PIPE-1:0][2:0] sr_q;
      always_ff @(posedge clk50 or posedge reset) begin
        if (reset)        sr_q <= '0;
        else if (!bus.en) sr_q <= '0;
        else if (tick) begin
          sr_q[0] <= flg0;
          for (int i = 1; i < PIPE; i++) sr_q[i] <= sr_q[i-1];
        end
      end
      assign flg_dly = sr_q[PIPE-1];
    end
  endgenerate

  logic [7:0] r_q, g_q, b_q;
  logic       act_q, hs_q, vs_q;

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset || !bus.en) begin
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
      act_q <= 1'b0;
      hs_q  <= 1'b0;
      vs_q  <= 1'b0;
    end else if (tick) begin
      r_q   <= flg_dly[2] ? bus.rgb_r : 8'h00;
      g_q   <= flg_dly[2] ? bus.rgb_g : 8'h00;
      b_q   <= flg_dly[2] ? bus.rgb_b : 8'h00;
      act_q <= flg_dly[2];
      hs_q  <= flg_dly[1];
      vs_q  <= flg_dly[0];
    end
  end

  assign bus.pix_hcount  = h_q;
  assign bus.pix_vcount  = v_q;
  assign bus.pix_tick    = tick;
  assign bus.line_start  = ls_q;
  assign bus.frame_start = fs_q;
  assign bus.vblank      = ({1'b0, v_q} >= V_ACT_E);
  assign bus.vga_r       = r_q;
  assign bus.vga_g       = g_q;
  assign bus.vga_b       = b_q;
  // Pixel clock rises mid-pixel so the DAC latches in the middle of a stable output.
  assign bus.vga_clk     = (div_q >= DIV_HALF);
  assign bus.vga_hs      = hs_q ^ ~HS_POL;
  assign bus.vga_vs      = vs_q ^ ~VS_POL;
  assign bus.vga_blank_n = act_q;
  assign bus.vga_sync_n  = 1'b1;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Checks two generator instances (small modes) against a cycle-count arithmetic model.
module tb_vga_timing_gen;
  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, cd, pipe;
    bit hp, vp;
  } mode_t;

  localparam int A_HA = 16, A_HF = 2, A_HS = 3, A_HB = 3, A_VA = 6, A_VF = 1, A_VS = 2, A_VB = 1;
  localparam int A_CD = 2, A_PIPE = 2;
  localparam int B_HA = 10, B_HF = 1, B_HS = 2, B_HB = 2, B_VA = 4, B_VF = 1, B_VS = 1, B_VB = 1;
  localparam int B_CD = 4, B_PIPE = 0;
  localparam int A_HT = A_HA + A_HF + A_HS + A_HB, A_VT = A_VA + A_VF + A_VS + A_VB;
  localparam int B_HT = B_HA + B_HF + B_HS + B_HB, B_VT = B_VA + B_VF + B_VS + B_VB;
  localparam int F0 = A_CD * A_HT * A_VT;
  localparam int F1 = B_CD * B_HT * B_VT;

  logic clk50 = 1'b0;
  logic reset = 1'b1;
  always #10 clk50 = ~clk50;

  vga_timing_gen_if #(.HW($clog2(A_HT)), .VW($clog2(A_VT))) if0 ();
  vga_timing_gen_if #(.HW($clog2(B_HT)), .VW($clog2(B_VT))) if1 ();

  vga_timing_gen #(
    .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
    .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
    .CLK_DIV(A_CD), .HS_POL(1'b0), .VS_POL(1'b0), .PIPE(A_PIPE)
  ) u_dut0 (.clk50(clk50), .reset(reset), .bus(if0));

  vga_timing_gen #(
    .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
    .CLK_DIV(B_CD), .HS_POL(1'b1), .VS_POL(1'b1), .PIPE(B_PIPE)
  ) u_dut1 (.clk50(clk50), .reset(reset), .bus(if1));

  mode_t md0, md1;
  int checks = 0, errors = 0, cyc = 0;
  int m0 = 0, m1 = 0;
  logic [23:0] cap0 = '0, cap1 = '0;
  bit align = 1'b0;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic int hpos(input mode_t md, input int p);
    if (p < 0) return 0;
    return p % (md.ha + md.hf + md.hs + md.hb);
  endfunction

  // m = clk50 edges seen with en=1 since the last reset/disable; everything follows from it.
  function automatic logic [64:0] model(input mode_t md, input int m, input bit en_now,
                                        input logic [23:0] cap, output int hq, output bit actq);
    int ht, vt, p, d, h, v, q, vq;
    bit hsa, vsa, ls;
    ht = md.ha + md.hf + md.hs + md.hb;
    vt = md.va + md.vf + md.vs + md.vb;
    p = m / md.cd;
    d = m % md.cd;
    h = p % ht;
    v = (p / ht) % vt;
    q = p - 1 - md.pipe;
    hq = 0; vq = 0; actq = 1'b0; hsa = 1'b0; vsa = 1'b0;
    if (q >= 0) begin
      hq   = q % ht;
      vq   = (q / ht) % vt;
      actq = (hq < md.ha) && (vq < md.va);
      hsa  = (hq >= md.ha + md.hf) && (hq < md.ha + md.hf + md.hs);
      vsa  = (vq >= md.va + md.vf) && (vq < md.va + md.vf + md.vs);
    end
    ls = (d == 0) && (p > 0) && (h == 0);
    return {16'(h), 16'(v), en_now && (d == md.cd - 1), ls, ls && (v == 0), v >= md.va,
            actq ? cap : 24'h0, d >= md.cd / 2, hsa ? md.hp : ~md.hp, vsa ? md.vp : ~md.vp,
            actq, 1'b1};
  endfunction

  function automatic logic [64:0] obs0();
    return {16'(if0.pix_hcount), 16'(if0.pix_vcount), if0.pix_tick, if0.line_start,
            if0.frame_start, if0.vblank, if0.vga_r, if0.vga_g, if0.vga_b, if0.vga_clk,
            if0.vga_hs, if0.vga_vs, if0.vga_blank_n, if0.vga_sync_n};
  endfunction

  function automatic logic [64:0] obs1();
    return {16'(if1.pix_hcount), 16'(if1.pix_vcount), if1.pix_tick, if1.line_start,
            if1.frame_start, if1.vblank, if1.vga_r, if1.vga_g, if1.vga_b, if1.vga_clk,
            if1.vga_hs, if1.vga_vs, if1.vga_blank_n, if1.vga_sync_n};
  endfunction

  task automatic check_now();
    int  hq0, hq1;
    bit  a0, a1;
    logic [64:0] e0, e1;
    e0 = model(md0, m0, if0.en, cap0, hq0, a0);
    e1 = model(md1, m1, if1.en, cap1, hq1, a1);
    chk("dut0_state", obs0(), e0);
    chk("dut1_state", obs1(), e1);
    if (align && a0) chk("dut0_align_r", 65'(if0.vga_r), 65'(hq0 & 8'hff));
    if (align && a1) chk("dut1_align_r", 65'(if1.vga_r), 65'(hq1 & 8'hff));
  endtask

  // One clk50 cycle: drive renderer data, cross the edge, compare 1 time unit later.
  task automatic step();
    if (align) begin
      if0.rgb_r = 8'(hpos(md0, m0 / md0.cd - md0.pipe));
      if1.rgb_r = 8'(hpos(md1, m1 / md1.cd - md1.pipe));
    end else begin
      if0.rgb_r = 8'($urandom);
      if1.rgb_r = 8'($urandom);
    end
    if0.rgb_g = 8'($urandom); if0.rgb_b = 8'($urandom);
    if1.rgb_g = 8'($urandom); if1.rgb_b = 8'($urandom);
    if (!reset && if0.en && (m0 % md0.cd == md0.cd - 1)) cap0 = {if0.rgb_r, if0.rgb_g, if0.rgb_b};
    if (!reset && if1.en && (m1 % md1.cd == md1.cd - 1)) cap1 = {if1.rgb_r, if1.rgb_g, if1.rgb_b};
    @(posedge clk50);
    m0 = (reset || !if0.en) ? 0 : m0 + 1;
    m1 = (reset || !if1.en) ? 0 : m1 + 1;
    #1;
    cyc++;
    check_now();
  endtask

  initial begin
    int fs0, last_fs1, last_ls0, hs_low0, hs_fall0, first0, first1;
    bit prev_hs0, prev_vbl0;
    md0 = '{A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, A_CD, A_PIPE, 1'b0, 1'b0};
    md1 = '{B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, B_CD, B_PIPE, 1'b1, 1'b1};
    if0.en = 1'b0; if1.en = 1'b0;
    if0.rgb_r = '0; if0.rgb_g = '0; if0.rgb_b = '0;
    if1.rgb_r = '0; if1.rgb_g = '0; if1.rgb_b = '0;

    // Reset state, then run into the middle of a line and reset asynchronously.
    repeat (3) step();
    reset = 1'b0; if0.en = 1'b1; if1.en = 1'b1;
    repeat (31) step();
    #2 reset = 1'b1;
    #1;
    m0 = 0; m1 = 0;
    check_now();
    repeat (3) step();
    reset = 1'b0;

    // Two frames: strobe counts/periods, HS width and position, frame wrap boundary.
    fs0 = 0; last_fs1 = -1; last_ls0 = -1; hs_low0 = 0; hs_fall0 = -1;
    prev_hs0 = if0.vga_hs; prev_vbl0 = if0.vblank;
    for (int i = 0; i < 2 * F0; i++) begin
      step();
      if (if0.frame_start) begin
        fs0++;
        chk("bnd_h", 65'(if0.pix_hcount), 65'd0);
        chk("bnd_v", 65'(if0.pix_vcount), 65'd0);
        chk("bnd_vblank", 65'(if0.vblank), 65'd0);
        chk("bnd_vblank_prev", 65'(prev_vbl0), 65'd1);
      end
      if (if1.frame_start) begin
        if (last_fs1 >= 0) chk("dut1_frame_period", 65'(cyc - last_fs1), 65'(F1));
        last_fs1 = cyc;
      end
      if (if0.line_start) begin
        if (last_ls0 >= 0) begin
          chk("line_period", 65'(cyc - last_ls0), 65'(A_CD * A_HT));
          chk("hs_low_cycles", 65'(hs_low0), 65'(A_CD * A_HS));
          chk("hs_fall_offset", 65'(hs_fall0), 65'((A_HA + A_HF + A_PIPE + 1) * A_CD));
        end
        last_ls0 = cyc; hs_low0 = 0; hs_fall0 = -1;
      end
      if (!if0.vga_hs) hs_low0++;
      if (prev_hs0 && !if0.vga_hs && last_ls0 >= 0) hs_fall0 = cyc - last_ls0;
      prev_hs0 = if0.vga_hs;
      prev_vbl0 = if0.vblank;
    end
    chk("frame_start_count", 65'(fs0), 65'd2);

    // Renderer returns its delayed column as red.
    align = 1'b1;
    repeat (F0) step();
    align = 1'b0;

    // Disable for 37 cycles mid-frame, then a full frame before the first frame_start.
    repeat (100) step();
    if0.en = 1'b0; if1.en = 1'b0;
    repeat (37) step();
    if0.en = 1'b1; if1.en = 1'b1;
    first0 = -1; first1 = -1;
    for (int i = 1; i <= 600; i++) begin
      step();
      if (first0 < 0 && if0.frame_start) first0 = i;
      if (first1 < 0 && if1.frame_start) first1 = i;
      if (first0 >= 0 && first1 >= 0) break;
    end
    chk("restart_fs0", 65'(first0), 65'(F0));
    chk("restart_fs1", 65'(first1), 65'(F1));

    // Random enable drops with random colour.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) if0.en = ~if0.en;
      if ($urandom_range(0, 39) == 0) if1.en = ~if1.en;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator and pixel output stage, the next generation of the fixed 640x480 emulator. It divides clk50 down to the pixel rate, generates H/V counters, sync, blank and frame/line strobes for any mode described by parameters, and has configurable sync polarity. It also compensates a fixed pixel-source pipeline latency, so that registered RGB, sync and blank leave the block aligned. It sits between the frame/sprite renderer, which consumes the coordinates and returns RGB, and the board VGA DAC pins.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33: vertical equivalents (lines)
- CLK_DIV, 2, clk50 cycles per pixel; legal values 2 or 4
- HS_POL, 0 and VS_POL, 0: sync active level (0 = active-low)
- PIPE, 2, pixel ticks between coordinate output and RGB input sample; legal range 0..7
- Derived: HTOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; VTOTAL likewise; HW = $clog2(HTOTAL); VW = $clog2(VTOTAL)

Ports:
- clk50  in  1  system clock (50 MHz)
- reset  in  1  asynchronous, active-high
- en  in  1  synchronous run enable
- rgb_r, rgb_g, rgb_b  in  8 each  pixel colour from renderer
- pix_hcount  out  HW  current pixel column (stage 0)
- pix_vcount  out  VW  current line (stage 0)
- pix_tick  out  1  one-clk50 strobe; counters advance on the following edge
- line_start, frame_start  out  1  one-clk50 strobes
- vblank  out  1  pix_vcount >= V_ACTIVE
- vga_r, vga_g, vga_b  out  8 each  registered colour
- vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n  out  1

## Operation
- Divider div_cnt counts 0..CLK_DIV-1 while en=1. pix_tick = en & (div_cnt==CLK_DIV-1). vga_clk = (div_cnt >= CLK_DIV/2), i.e. it rises mid-pixel.
- On pix_tick: h wraps at HTOTAL-1 to 0, otherwise increments. v increments only when h wraps, and wraps at VTOTAL-1 to 0.
- Stage-0 decode: act = (h<H_ACTIVE)&(v<V_ACTIVE). hs0 is active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vs0 is active for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), over whole lines.
- Delay line: {act, hs0, vs0} shift through PIPE stages, advancing only on pix_tick. On the same pix_tick, the output register captures the delayed flags and RGB.
- Output: vga_rgb = delayed act ? rgb_* : 0. vga_hs = hs_d ^ ~HS_POL, so that the sync level equals HS_POL when active; vga_vs likewise. vga_blank_n = act_d. vga_sync_n is tied to 1.
- line_start is asserted in the clk50 cycle after a tick that loads h=0. frame_start is the same with h=0 and v=0.
- en=0: div_cnt, h, v, the delay line and the outputs are forced synchronously to their reset values. On the cycle after en rises, div_cnt=0 and counting begins; the first frame_start fires after CLK_DIV·HTOTAL·VTOTAL cycles. The (0,0) position at enable is not flagged.

## Timing
- Reset (asynchronous): div_cnt, h and v = 0; delay line and output register blanked with sync inactive; vga_rgb = 0; vga_blank_n = 0; vga_hs = ~HS_POL; vga_vs = ~VS_POL; vga_clk = 0; all strobes 0.
- Latency: the DAC outputs for coordinate (h,v) appear PIPE+1 pixel ticks, i.e. (PIPE+1)·CLK_DIV clk50 cycles, after pix_hcount=h first shows.
- The RGB sample is taken on the pix_tick edge PIPE ticks after the coordinate; the renderer must hold valid data there.
- Frame period: CLK_DIV·HTOTAL·VTOTAL clk50 cycles exactly. The line period is CLK_DIV·HTOTAL.
- A simultaneous h wrap and v wrap is a single-tick event: both counters go to 0 together.
- Outputs change only on the clk50 edge after pix_tick, except vga_clk, which is decoded from div_cnt.

## Test plan
- Reset mid-line, then release with en=1 (defaults): after 1,680,000 cycles exactly 2 frame_start pulses; line_start every 1600 cycles.
- HS check (defaults): vga_hs is low for 192 clk50 cycles per line. Its falling edge is (656+3)·2 = 1318 cycles after line_start.
- Pipeline alignment: drive rgb_r = pix_hcount[7:0] delayed PIPE ticks. Every active pixel must show vga_r = its column low byte, with zero during blank.
- PIPE=0, CLK_DIV=4, HS_POL=1, VS_POL=1, 800x600-style parameters: HS is high when active, the frame period equals 4·HTOTAL·VTOTAL, and vga_clk has a 2-high/2-low pattern.
- Drop en for 37 cycles mid-frame: all outputs return to reset values within 1 cycle. On restart h=v=0 and the first frame_start arrives after a full frame.
- Boundary: at h=HTOTAL-1, v=VTOTAL-1, one tick gives (0,0), frame_start=1 and vblank falling to 0 in the same cycle.
